// File: rtl/mem_arbiter_if.sv
// Request/acknowledge and memory-strobe bundle shared by the arbiter, the core
// requesters and the 256x8 main memory.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_opcode;
    logic [DW-1:0] if_operand;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_write_en;
    logic          mem_read_en;
    logic          mem_ir_en;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] mem_ir_out;
    logic          busy;

    // arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out, mem_ir_out,
        output if_ack, if_opcode, if_operand, d_ack, d_rdata,
               mem_write_en, mem_read_en, mem_ir_en, mem_add, mem_data_in, busy
    );

    // requesters + memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out, mem_ir_out,
        input  if_ack, if_opcode, if_operand, d_ack, d_rdata,
               mem_write_en, mem_read_en, mem_ir_en, mem_add, mem_data_in, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and access sequencer for the single-port main memory.
// MEM_ARB_RR_EN selects round-robin contention handling; default is data-over-fetch.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_t;
    typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE} op_t;

    typedef struct packed {
        op_t           op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state, state_nxt;
    req_t          cur;
    logic          grant_d, grant_f;
    logic [DW-1:0] opcode_q, operand_q, rdata_q;

`ifdef MEM_ARB_RR_EN
    logic last_d;  // 1 = data won the previous grant

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_d <= 1'b0;
        else if (state == IDLE && (grant_d || grant_f))
            last_d <= grant_d;
    end
`endif

    always_comb begin
        grant_d = 1'b0;
        grant_f = 1'b0;
        if (bus.d_req && bus.if_req) begin
`ifdef MEM_ARB_RR_EN
            grant_d = !last_d;
            grant_f = last_d;
`else
            grant_d = 1'b1;
`endif
        end else begin
            grant_d = bus.d_req;
            grant_f = bus.if_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_d || grant_f) state_nxt = ISSUE;
            ISSUE:   state_nxt = (cur.op == OP_WRITE) ? ACK : CAPT;
            CAPT:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and result capture; later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && grant_d) begin
                cur.op    <= bus.d_we ? OP_WRITE : OP_READ;
                cur.addr  <= bus.d_addr;
                cur.wdata <= bus.d_wdata;
            end else if (state == IDLE && grant_f) begin
                cur.op   <= OP_FETCH;
                cur.addr <= bus.if_addr;
            end
            if (state == CAPT) begin
                if (cur.op == OP_FETCH) begin
                    opcode_q  <= bus.mem_data_out;
                    operand_q <= bus.mem_ir_out;
                end else begin
                    rdata_q <= bus.mem_data_out;
                end
            end
        end
    end

    // Strobes are gated by rst_n so a reset edge can never commit a write.
    always_comb begin
        bus.mem_write_en = 1'b0;
        bus.mem_read_en  = 1'b0;
        bus.mem_ir_en    = 1'b0;
        bus.if_ack       = 1'b0;
        bus.d_ack        = 1'b0;
        case (state)
            ISSUE: begin
                if (rst_n) begin
                    case (cur.op)
                        OP_FETCH: begin
                            bus.mem_read_en = 1'b1;
                            bus.mem_ir_en   = 1'b1;
                        end
                        OP_READ:  bus.mem_read_en  = 1'b1;
                        OP_WRITE: bus.mem_write_en = 1'b1;
                        default:  ;
                    endcase
                end
            end
            ACK: begin
                bus.if_ack = (cur.op == OP_FETCH);
                bus.d_ack  = (cur.op != OP_FETCH);
            end
            default: ;
        endcase
        bus.busy = (state != IDLE);
    end

    assign bus.mem_add     = cur.addr;
    assign bus.mem_data_in = cur.wdata;
    assign bus.if_opcode   = opcode_q;
    assign bus.if_operand  = operand_q;
    assign bus.d_rdata     = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares every ack the arbiter produces.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mem_arbiter_if #(.AW(8), .DW(8)) bus ();

    mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 256x8 memory with registered read and IR ports
    logic [7:0] mem [256];
    logic [7:0] nxt_add;
    assign nxt_add = bus.mem_add + 8'd1;
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_add] <= bus.mem_data_in;
        if (bus.mem_read_en)  bus.mem_data_out <= mem[bus.mem_add];
        if (bus.mem_ir_en)    bus.mem_ir_out   <= mem[nxt_add];
    end

    typedef struct {
        bit         fetch;
        bit         we;
        logic [7:0] d0;
        logic [7:0] d1;
        int         cyc;   // -1: ack cycle not checked
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic void push(input bit f, input bit we, input logic [7:0] d0,
                                 input logic [7:0] d1, input int c);
        exp_t e;
        e.fetch = f; e.we = we; e.d0 = d0; e.d1 = d1; e.cyc = c;
        sbq.push_back(e);
    endfunction

    // monitor
    always @(negedge clk) begin
        if (bus.d_ack || bus.if_ack) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("ack_port", {31'd0, bus.if_ack}, {31'd0, e.fetch});
                if (e.fetch) begin
                    check("if_opcode", bus.if_opcode, e.d0);
                    check("if_operand", bus.if_operand, e.d1);
                end else if (!e.we) begin
                    check("d_rdata", bus.d_rdata, e.d0);
                end
                if (e.cyc >= 0) check("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ack(input bit fetch, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = fetch ? bus.if_ack : bus.d_ack;
        end
        if (!seen) check(nm, 32'd0, 32'd1);
    endtask

    task automatic data_xfer(input bit we, input logic [7:0] a, input logic [7:0] wd,
                             input logic [7:0] rd);
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        push(1'b0, we, rd, 8'h00, cyc + (we ? 2 : 3));
        wait_ack(1'b0, "d_ack_timeout");
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int st, nd, nf;
        // reset with both requests pending
        rst_n = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h30; bus.d_wdata = 8'h99;
        bus.if_req = 1'b1; bus.if_addr = 8'h40;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_strobes", {29'd0, bus.mem_write_en, bus.mem_read_en, bus.mem_ir_en}, 32'd0);
            check("rst_acks_busy", {29'd0, bus.if_ack, bus.d_ack, bus.busy}, 32'd0);
            check("rst_data", {bus.if_opcode, bus.if_operand, bus.d_rdata}, 32'd0);
            check("rst_mem_bus", {bus.mem_add, bus.mem_data_in}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        st = cyc;
        push(1'b0, 1'b1, 8'h00, 8'h00, st + 2);
        @(negedge clk);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("first_grant_data", {29'd0, bus.mem_write_en, bus.mem_read_en, bus.mem_ir_en}, 32'd4);
        check("issue_addr", bus.mem_add, 32'h30);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        wait_ack(1'b0, "first_ack_timeout");
        @(posedge clk); #1;

        // write then read back
        data_xfer(1'b1, 8'h10, 8'hA5, 8'h00);
        data_xfer(1'b0, 8'h10, 8'h00, 8'hA5);
        data_xfer(1'b0, 8'h30, 8'h00, 8'h99);
        data_xfer(1'b1, 8'hFF, 8'h3C, 8'h00);
        data_xfer(1'b1, 8'h00, 8'h7E, 8'h00);
        data_xfer(1'b1, 8'h20, 8'h11, 8'h00);

        // fetch at the top of memory wraps the operand to address 0
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 8'hFF;
        st = cyc;
        push(1'b1, 1'b0, 8'h3C, 8'h7E, st + 3);
        @(negedge clk);
        check("fetch_c0_strobes", {30'd0, bus.mem_read_en, bus.mem_ir_en}, 32'd0);
        @(negedge clk);
        check("fetch_c1_strobes", {30'd0, bus.mem_read_en, bus.mem_ir_en}, 32'd3);
        @(negedge clk);
        check("fetch_c2_strobes", {30'd0, bus.mem_read_en, bus.mem_ir_en}, 32'd0);
        wait_ack(1'b1, "if_ack_timeout");
        @(posedge clk); #1;
        bus.if_req = 1'b0;

        // contention: both held continuously
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10;
        bus.if_req = 1'b1; bus.if_addr = 8'hFF;
        nd = 0; nf = 0;
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, 8'hA5, 8'h00, -1);
            push(1'b1, 1'b0, 8'h3C, 8'h7E, -1);
        end
        for (int i = 0; i < 200 && (nd + nf) < 6; i++) begin
            @(negedge clk);
            if (bus.d_ack) nd++;
            if (bus.if_ack) nf++;
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        check("rr_ack_total", nd + nf, 6);
        check("rr_balance", {31'd0, ((nd > nf) ? nd - nf : nf - nd) <= 1}, 32'd1);
`else
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 8'hA5, 8'h00, -1);
        for (int i = 0; i < 200 && nd < 4; i++) begin
            @(negedge clk);
            if (bus.d_ack) nd++;
            if (bus.if_ack) nf++;
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        check("prio_d_acks", nd, 4);
        check("fetch_starved", nf, 0);
        st = cyc;
        push(1'b1, 1'b0, 8'h3C, 8'h7E, st + 3);
        wait_ack(1'b1, "starved_fetch_timeout");
        @(posedge clk); #1;
        bus.if_req = 1'b0;
`endif

        // reset in the ISSUE cycle of a write drops it
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 8'h55;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_issue_we", {31'd0, bus.mem_write_en}, 32'd0);
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (4) @(negedge clk);
        data_xfer(1'b0, 8'h20, 8'h00, 8'h11);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-requester arbiter and sequencer for the 256×8 single-port main memory.
- Shares the memory between the instruction-fetch path and the load/store data path.
- Drives the memory's write, read and IR strobes and its address and write data.
- Captures the registered read results and returns them with a one-cycle acknowledge; the core never drives the memory directly.

## Interface
Parameters:
- AW, 8, address width (memory depth 2^AW)
- DW, 8, data width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held high with if_addr stable until if_ack
- if_addr  in  AW  fetch address (opcode byte)
- if_ack  out  1  one-cycle pulse: if_opcode/if_operand valid
- if_opcode  out  DW  mem[if_addr]
- if_operand  out  DW  mem[(if_addr+1) mod 2^AW]
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle pulse: write committed, or d_rdata valid
- d_rdata  out  DW  read data
- mem_write_en, mem_read_en, mem_ir_en  out  1 each  memory strobes
- mem_add  out  AW  memory address
- mem_data_in  out  DW  memory write data
- mem_data_out, mem_ir_out  in  DW each  memory read results (valid only in the cycle after the strobe)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, CAPT, ACK.
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending: grant it; latch op type (fetch / read / write), address and wdata; go to ISSUE.
- Requester changes after grant are ignored.
- ISSUE strobes (Moore, from state register):
  - fetch: mem_read_en=1 and mem_ir_en=1
  - data read: mem_read_en=1
  - data write: mem_write_en=1
  - Next state: write → ACK; read/fetch → CAPT.
- CAPT: register mem_data_out into if_opcode or d_rdata; register mem_ir_out into if_operand (fetch only). Next state ACK.
- ACK: pulse if_ack or d_ack for exactly one cycle; next state IDLE.
- Output data registers hold their value until the next capture of the same port.
- Strobes are 0 in every state except ISSUE.
- mem_add and mem_data_in hold the last latched values; they are never X after reset.
- Arbitration when only one req is high: grant that requester.
- Arbitration when both are high: see Configuration.
- A req still high in the IDLE cycle after its ack is treated as a new request.
- Operand address wraps modulo 2^AW: fetch at 0xFF returns mem[0xFF] and mem[0x00].

## Timing
- Cycle 0 = IDLE with req sampled high.
- Write: strobe in cycle 1, memory updated at the end of cycle 1, d_ack in cycle 2. Three cycles per access including IDLE.
- Read/fetch: strobe in cycle 1, data captured at the end of cycle 2, ack and data valid in cycle 3. Four cycles per access.
- Reset (rst_n low at an edge):
  - next cycle: state IDLE; all outputs 0 (acks, strobes, busy, if_opcode, if_operand, d_rdata, mem_add, mem_data_in)
  - rr pointer set so data wins first
- Reset mid-operation: the transaction is dropped with no ack.
- mem_* strobes are combinationally forced to 0 while rst_n is low, so no write commits at a reset edge.
- Simultaneous if_req and d_req rising in the same cycle: exactly one is granted; the other waits in IDLE for the next decision.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On contention, grant the requester not granted last; neither port can starve.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. A continuously asserted d_req starves fetch.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with both reqs high → all outputs 0; no strobe while rst_n=0; first grant after release is data.
- Write then read: d_we=1, d_addr=0x10, d_wdata=0xA5 → d_ack at cycle 2. Then d_we=0, d_addr=0x10 → d_ack at cycle 3 with d_rdata=0xA5.
- Fetch with wrap: preload mem[0xFF]=0x3C, mem[0x00]=0x7E; if_addr=0xFF → if_ack at cycle 3, if_opcode=0x3C, if_operand=0x7E; mem_read_en and mem_ir_en high in cycle 1 only.
- Contention with RR: both reqs held continuously → grants alternate D, F, D, F; ack count equal ±1 over 40 cycles.
- Contention without RR: both reqs held continuously → only d_ack pulses and if_ack stays 0; dropping d_req → if_ack after 4 cycles.
- Reset mid-write: assert rst_n=0 during ISSUE of a write of 0x55 to 0x20 (old value 0x11) → no d_ack, mem_write_en low; read of 0x20 returns 0x11.
